// File: rtl/div_ctrl.sv
// Radix-2 restoring divide controller for DIV/DIVU with a pipeline stall request.
// Latency: ready DW+1 cycles after acceptance (2 cycles for a zero divisor).
// Backpressure: stall_req holds upstream while start is held; cancel aborts in any state.
module div_ctrl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          signed_div,
  input  logic [DW-1:0] opr1,
  input  logic [DW-1:0] opr2,
  input  logic          cancel,
  output logic          stall_req,
  output logic          ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] ONE = DW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_BUSY, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dvd;    // dividend shifting out, quotient bits shifting in
  logic [DW-1:0] r_dvs;    // divisor magnitude
  logic [DW-1:0] r_p;      // partial remainder
  logic [DW-1:0] r_quot, r_rem;
  logic          r_neg_q, r_neg_r;

  logic          w_accept, w_dvs_zero, w_ge;
  logic [DW-1:0] w_abs1, w_abs2, w_p_sub, w_p_nxt, w_q_fin, w_r_fin;
  logic [DW:0]   w_p_sh;

  assign w_accept   = (r_state == S_IDLE) & start & ~cancel;
  assign w_dvs_zero = (opr2 == '0);
  // abs(most negative) wraps to itself and is then used as an unsigned magnitude.
  assign w_abs1     = (signed_div & opr1[DW-1]) ? (~opr1 + ONE) : opr1;
  assign w_abs2     = (signed_div & opr2[DW-1]) ? (~opr2 + ONE) : opr2;

  // One restoring step: the partial remainder keeps its carry bit so divisors above 2^(DW-1) work.
  assign w_p_sh  = {r_p, r_dvd[DW-1]};
  assign w_ge    = (w_p_sh >= {1'b0, r_dvs});
  assign w_p_sub = w_p_sh[DW-1:0] - r_dvs;
  assign w_p_nxt = w_ge ? w_p_sub : w_p_sh[DW-1:0];

  // Sign fix-up; the flags are never set for a zero divisor, so that result stays raw.
  assign w_q_fin = r_neg_q ? (~r_dvd + ONE) : r_dvd;
  assign w_r_fin = r_neg_r ? (~r_p + ONE) : r_p;

  assign ready     = (r_state == S_DONE) & ~cancel;
  assign quotient  = ready ? w_q_fin : r_quot;
  assign remainder = ready ? w_r_fin : r_rem;
  assign stall_req = resetn & start & ~cancel & (r_state != S_DONE);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; cancel overrides everything and returns to IDLE.
  always_comb begin
    w_next = r_state;
    if (cancel) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_next = w_dvs_zero ? S_ZERO : S_BUSY;
        S_ZERO: w_next = S_DONE;
        S_BUSY: if (r_cnt == CW'(DW - 1)) w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Operand capture, iteration datapath and result hold registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_p     <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_dvs   <= w_abs2;
        r_neg_q <= signed_div & ~w_dvs_zero & (opr1[DW-1] ^ opr2[DW-1]);
        r_neg_r <= signed_div & ~w_dvs_zero & opr1[DW-1];
        // Zero divisor: preload the final answer so ZERO/DONE need no datapath work.
        r_p     <= w_dvs_zero ? opr1 : '0;
        r_dvd   <= w_dvs_zero ? '1 : w_abs1;
      end else if ((r_state == S_BUSY) && !cancel) begin
        r_p     <= w_p_nxt;
        r_dvd   <= {r_dvd[DW-2:0], w_ge};
        r_cnt   <= r_cnt + 1'b1;
      end
      if (ready) begin
        r_quot <= w_q_fin;
        r_rem  <= w_r_fin;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed vector table, cancel/reset sequences,
// and randomized divides compared against an arithmetic reference model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn, start, signed_div, cancel;
  logic [31:0] opr1, opr2;
  logic        stall_req, ready;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_ctrl #(.DW(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .opr1(opr1), .opr2(opr2), .cancel(cancel), .stall_req(stall_req),
    .ready(ready), .quotient(quotient), .remainder(remainder)
  );

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer division on magnitudes, signs applied afterwards.
  function automatic void model(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ma, mb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sd) begin
      q = a / b;
      r = a % b;
    end else begin
      ma = a[31] ? 32'd0 - a : a;
      mb = b[31] ? 32'd0 - b : b;
      q  = ma / mb;
      r  = ma % mb;
      if (a[31] ^ b[31]) q = 32'd0 - q;
      if (a[31]) r = 32'd0 - r;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the DONE cycle.
  task automatic do_div(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    int  k;
    bit  got;
    int  elat;
    elat = (b == 32'd0) ? 2 : 33;
    signed_div = sd; opr1 = a; opr2 = b; start = 1'b1; cancel = 1'b0;
    #1 check({tag, "_stall_accept"}, 32'(stall_req), 32'd1);
    k = 0; got = 0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (ready) begin
        got = 1;
      end else begin
        // Later operand changes must be ignored.
        opr1 = $urandom; opr2 = $urandom; signed_div = 1'($urandom);
      end
    end
    check({tag, "_latency"}, 32'(k), 32'(elat));
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_stall_done"}, 32'(stall_req), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_ready_pulse"}, 32'(ready), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, mq, mr;
    logic        rsd;
    bit          saw_ready;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vecs[3] = '{1'b0, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF, 32'h0000_1234};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1,        32'd1};
    vecs[7] = '{1'b1, 32'h8000_0000,  32'd2,        32'hC000_0000, 32'd0};

    resetn = 1'b0; start = 1'b1; cancel = 1'b0; signed_div = 1'b0;
    opr1 = 32'd100; opr2 = 32'd7;
    #7;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    resetn = 1'b1; start = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) do_div($sformatf("vec%0d", i), vecs[i].sd, vecs[i].a, vecs[i].b,
                             vecs[i].q, vecs[i].r);

    // Results hold while idle.
    repeat (3) @(negedge clk);
    check("hold_quotient", quotient, vecs[7].q);
    check("hold_remainder", remainder, vecs[7].r);

    // Cancel at cycle 10, new divide accepted at cycle 11.
    signed_div = 1'b0; opr1 = 32'd1000; opr2 = 32'd3; start = 1'b1;
    saw_ready = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ready) saw_ready = 1;
    end
    cancel = 1'b1;
    #1 check("cancel_stall", 32'(stall_req), 32'd0);
    check("cancel_ready", 32'(ready), 32'd0);
    @(negedge clk);
    if (ready) saw_ready = 1;
    check("cancel_no_ready", 32'(saw_ready), 32'd0);
    check("cancel_keeps_quotient", quotient, vecs[7].q);
    do_div("after_cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Asynchronous reset in the middle of a divide.
    signed_div = 1'b0; opr1 = 32'd77; opr2 = 32'd5; start = 1'b1;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    resetn = 1'b1; start = 1'b0;
    @(negedge clk);
    do_div("after_reset", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

    // Randomized divides against the reference model.
    for (int n = 0; n < 40; n++) begin
      rsd = 1'($urandom);
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      model(rsd, ra, rb, mq, mr);
      do_div($sformatf("rand%0d", n), rsd, ra, rb, mq, mr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle divide unit controller for the EX stage; sequences a radix-2 restoring divider, one quotient bit per cycle.
- Serves DIV/DIVU; raises a stall request to hold the pipeline while busy.
- Returns quotient (LO) and remainder (HI) to the HI/LO write path.
- Honours pipeline flush (cancel) and asynchronous reset at any point.

Parameters:
DW, 32, operand/result width; iteration count equals DW.

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  EX holds a divide; level, held by EX while stalled
signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE
opr1  in  DW  dividend (rs value after forwarding)
opr2  in  DW  divisor (rt value after forwarding)
cancel  in  1  flush of the EX instruction; synchronous abort
stall_req  out  1  hold upstream stages
ready  out  1  result valid this cycle (one-cycle pulse)
quotient  out  DW  quotient, to LO
remainder  out  DW  remainder, to HI

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset (resetn=0, asynchronous, any state including mid-divide):
  - state=IDLE; ready=0; quotient=0; remainder=0; iteration counter=0; internal registers cleared.
  - stall_req=0 while reset is asserted.
- States: IDLE, ZERO, BUSY, DONE.
- IDLE:
  - start=1 and cancel=0: latch opr1, opr2, signed_div.
  - Latched divisor == 0: go to ZERO. Otherwise go to BUSY with counter=0.
  - Signed mode: latch absolute values; record neg_q = opr1[DW-1]^opr2[DW-1] and neg_r = opr1[DW-1].
- BUSY:
  - Each cycle: partial remainder p = {p[DW-2:0], dividend MSB}; shift dividend left.
  - If p >= divisor, subtract divisor and set quotient bit to 1; else quotient bit 0. Use a DW+1-bit compare/subtract.
  - Counter increments each cycle; after DW iterations (counter == DW-1 in this cycle) go to DONE.
- ZERO: one cycle, then go to DONE with quotient = all ones and remainder = latched dividend (raw, unsigned view).
- DONE:
  - Signed mode: negate quotient if neg_q; negate remainder if neg_r.
  - ready=1 for exactly this cycle; quotient and remainder are valid.
  - Next state is IDLE unconditionally.
- quotient and remainder hold their last values after DONE until the next DONE or reset.
- Latency from start accepted in IDLE (cycle 0):
  - Normal divide: ready in cycle DW+1 (33 for DW=32).
  - Divide by zero: ready in cycle 2.
- stall_req = start & ~cancel & (state != DONE). It is combinational, so it is high in the accepting IDLE cycle and low in the DONE cycle, which lets the pipeline advance.
- Re-trigger: start seen high in IDLE after DONE is treated as a new instruction. EX must deassert start for a divide instruction that has completed.
- Operand changes on opr1/opr2/signed_div after acceptance are ignored.
- cancel:
  - In any state, go to IDLE next cycle; ready stays 0; quotient/remainder are not updated.
  - cancel has priority over start in the same cycle; no acceptance occurs.
  - A new start is accepted the cycle after the abort.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (two's complement wrap, no exception).
- Magnitude: abs(0x80000000) is 0x80000000 and is treated as unsigned inside the iteration.

Test Plan:
- Unsigned divide: DIVU 100/7 (start held) -> stall_req high cycles 0-32; ready pulses at cycle 33 with quotient=14, remainder=2; stall_req low in that cycle.
- Signed negative dividend: DIV -7/2 (0xFFFFFFF9/0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: DIVU 0x1234/0 -> ready at cycle 2 with quotient=0xFFFFFFFF, remainder=0x00001234.
- Signed overflow and full-width unsigned: DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Cancel mid-divide: cancel at cycle 10 -> state IDLE at cycle 11, no ready pulse, stall_req=0. New DIVU 9/3 accepted at cycle 11 -> ready at cycle 44 with quotient=3, remainder=0.
- Reset mid-divide: resetn low at cycle 5 (mid-cycle) -> ready=0, quotient=0, remainder=0, stall_req=0 immediately. After release, 50/5 gives quotient=10 after the full latency.
